sdram_frame_arbiter: RTL
========================

// Module: sdram_frame_arbiter
// PURPOSE
//  Shares the single-port SDRAM burst controller between the camera write path and the VGA read path.
//  Picks one requester per burst and drives the controller's command handshake.
//  Generates the per-requester frame addresses and steers the data path through grant outputs.
//  Sits between the camera/VGA FIFOs and the SDRAM controller inside top.
// PARAMETERS
//  ADDR_W      22      SDRAM word address width
//  LVL_W       10      width of FIFO level/space inputs
//  BURST_LEN   8       words per burst; address step per completed burst
//  FRAME_WORDS 307200  words per frame (640x480 RGB565); must be a multiple of BURST_LEN
//  RD_URGENT   384     read-FIFO free space at/above which read gets absolute priority
//  FRAME_BASE1 22'h080000  base of second frame buffer (ARB_DOUBLE_BUFFER_EN only)
// PORTS
//  clk_i          in   1       system clock (SDRAM controller domain)
//  rst_i          in   1       asynchronous reset, active-high
//  wr_level_i     in   LVL_W   camera write FIFO fill level (words)
//  wr_vsync_i     in   1       1-cycle pulse: camera frame start (already synchronised)
//  rd_space_i     in   LVL_W   VGA read FIFO free space (words)
//  rd_vsync_i     in   1       1-cycle pulse: VGA frame start (already synchronised)
//  cmd_valid_o    out  1       burst command valid to SDRAM controller
//  cmd_ready_i    in   1       controller accepts command when valid&ready
//  cmd_we_o       out  1       1 = write burst, 0 = read burst
//  cmd_addr_o     out  ADDR_W  burst start address
//  burst_done_i   in   1       1-cycle pulse: last word of current burst transferred
//  grant_wr_o     out  1       camera FIFO owns the data path
//  grant_rd_o     out  1       VGA FIFO owns the data path
//  busy_o         out  1       state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, wr_addr=rd_addr=0, last_grant=RD, vsync pending flags 0.
//  FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE.
//   IDLE: wr_elig = wr_level_i>=BURST_LEN; rd_elig = rd_space_i>=BURST_LEN.
//    rd_elig & rd_space_i>=RD_URGENT -> read. Else both eligible -> opposite of last_grant.
//    Else the single eligible one. None -> stay. Decision registered; go ISSUE next cycle.
//   ISSUE: cmd_valid_o=1, cmd_we_o/cmd_addr_o/grant stable until valid&ready; then WAIT_DONE.
//   WAIT_DONE: cmd_valid_o=0, grant held; on burst_done_i: advance owner addr, update last_grant, -> IDLE.
//  Min 3 cycles IDLE-to-IDLE (ready and done same-cycle-as-possible); no new command before done.
//  grant_wr_o/grant_rd_o one-hot in ISSUE/WAIT_DONE, both 0 in IDLE.
//  Address: offset += BURST_LEN; offset == FRAME_WORDS-BURST_LEN wraps to 0 (per requester).
//  cmd_addr_o = base + offset; width ADDR_W, no carry beyond.
//  Vsync: sets pending flag for that requester; flag applied (offset:=0, flag cleared) only in IDLE.
//   Vsync during a burst of that requester: burst completes and advances, then offset reset to 0.
//   Vsync coincident with burst_done_i: reset wins (offset ends 0).
//  cmd_ready_i/burst_done_i outside ISSUE/WAIT_DONE ignored.
//  Async reset mid-burst: immediate return to reset values; controller must be reset together.
// CONFIGURATION
//  ARB_DOUBLE_BUFFER_EN defined: writer base toggles 0<->FRAME_BASE1 on each applied wr vsync.
//   Reader latches base = the buffer writer just left, on each applied rd vsync (no tearing).
//  Not defined: both bases fixed at 0 (single buffer); FRAME_BASE1 unused.
// TESTING
//  Reset -> all outputs 0, busy_o=0; hold wr_level=0, rd_space=0 for 20 cycles -> no cmd_valid_o.
//  wr_level=16, rd_space=0, ready=1, done 4 cycles after accept -> write bursts at 0,8,16; we=1.
//  wr_level=16, rd_space=100 -> alternating grants W,R,W,R (first W since last_grant=RD).
//  wr_level=16, rd_space=400 -> four consecutive read bursts, no write until rd_space<384.
//  Drive write bursts to offset 307192 -> next cmd_addr_o=0; wr_vsync mid-burst -> next addr 0.
//  ARB_DOUBLE_BUFFER_EN: wr_vsync, 2 writes, rd_vsync -> writes at 0x80000.., reads from 0.

Source files
------------

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates SDRAM bursts between the camera write path and the VGA read path, one burst at a time.
// Optional ARB_DOUBLE_BUFFER_EN: writer ping-pongs between two frame buffers, reader trails it.
module sdram_frame_arbiter #(
   parameter int ADDR_W      = 22,
   parameter int LVL_W       = 10,
   parameter int BURST_LEN   = 8,
   parameter int FRAME_WORDS = 307200,
   parameter int RD_URGENT   = 384,
   parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(22'h080000)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [LVL_W-1:0]  wr_level_i,
   input  logic              wr_vsync_i,
   input  logic [LVL_W-1:0]  rd_space_i,
   input  logic              rd_vsync_i,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   output logic              cmd_we_o,
   output logic [ADDR_W-1:0] cmd_addr_o,
   input  logic              burst_done_i,
   output logic              grant_wr_o,
   output logic              grant_rd_o,
   output logic              busy_o,
   output logic [1:0]        dbg_state_o
);
   // Handshake: a command is transferred on the cycle cmd_valid_o & cmd_ready_i are both high;
   // cmd_valid_o, cmd_we_o and cmd_addr_o stay stable until then, and nothing new is issued
   // before burst_done_i closes the current burst.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] LAST_OFF   = ADDR_W'(FRAME_WORDS - BURST_LEN);
   localparam logic [LVL_W-1:0]  LVL_BURST  = LVL_W'(BURST_LEN);
   localparam logic [LVL_W-1:0]  LVL_URGENT = LVL_W'(RD_URGENT);

   state_t            state_q, state_d;
   logic              own_wr_q, own_wr_d;
   logic              last_wr_q;
   logic [ADDR_W-1:0] wr_off_q, rd_off_q;
   logic              wr_pend_q, rd_pend_q;
   logic              wr_buf, rd_buf;
   logic [ADDR_W-1:0] wr_base, rd_base;
   logic              wr_elig, rd_elig, rd_urgent;
   logic              in_idle, wr_apply, rd_apply, done_ev;

   assign wr_elig   = wr_level_i >= LVL_BURST;
   assign rd_elig   = rd_space_i >= LVL_BURST;
   assign rd_urgent = rd_elig && (rd_space_i >= LVL_URGENT);
   assign in_idle   = (state_q == IDLE);
   // A vsync seen in IDLE takes effect immediately, so the burst chosen that cycle already uses it.
   assign wr_apply  = in_idle && (wr_pend_q || wr_vsync_i);
   assign rd_apply  = in_idle && (rd_pend_q || rd_vsync_i);
   assign done_ev   = (state_q == WAIT_DONE) && burst_done_i;

   always_comb begin
      state_d  = state_q;
      own_wr_d = own_wr_q;
      case (state_q)
         IDLE: begin
            if (rd_urgent) begin
               own_wr_d = 1'b0;
               state_d  = ISSUE;
            end else if (wr_elig && rd_elig) begin
               own_wr_d = !last_wr_q;
               state_d  = ISSUE;
            end else if (wr_elig) begin
               own_wr_d = 1'b1;
               state_d  = ISSUE;
            end else if (rd_elig) begin
               own_wr_d = 1'b0;
               state_d  = ISSUE;
            end
         end
         ISSUE:     if (cmd_ready_i) state_d = WAIT_DONE;
         WAIT_DONE: if (burst_done_i) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         own_wr_q  <= 1'b0;
         last_wr_q <= 1'b0;
         wr_pend_q <= 1'b0;
         rd_pend_q <= 1'b0;
         wr_off_q  <= '0;
         rd_off_q  <= '0;
      end else begin
         state_q   <= state_d;
         own_wr_q  <= own_wr_d;
         if (done_ev) last_wr_q <= own_wr_q;
         wr_pend_q <= in_idle ? 1'b0 : (wr_pend_q || wr_vsync_i);
         rd_pend_q <= in_idle ? 1'b0 : (rd_pend_q || rd_vsync_i);
         // Apply only happens in IDLE and advance only in WAIT_DONE, so they never collide.
         if (wr_apply)
            wr_off_q <= '0;
         else if (done_ev && own_wr_q)
            wr_off_q <= (wr_off_q == LAST_OFF) ? '0 : wr_off_q + STEP;
         if (rd_apply)
            rd_off_q <= '0;
         else if (done_ev && !own_wr_q)
            rd_off_q <= (rd_off_q == LAST_OFF) ? '0 : rd_off_q + STEP;
      end
   end

`ifdef ARB_DOUBLE_BUFFER_EN
   // Reader always takes the buffer the writer most recently finished, so it never sees a half frame.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_buf <= 1'b0;
         rd_buf <= 1'b0;
      end else begin
         if (wr_apply) wr_buf <= !wr_buf;
         if (rd_apply) rd_buf <= wr_apply ? wr_buf : !wr_buf;
      end
   end
`else
   assign wr_buf = 1'b0;
   assign rd_buf = 1'b0;
`endif

   assign wr_base = wr_buf ? FRAME_BASE1 : '0;
   assign rd_base = rd_buf ? FRAME_BASE1 : '0;

   assign busy_o      = !in_idle;
   assign cmd_valid_o = (state_q == ISSUE);
   assign grant_wr_o  = busy_o && own_wr_q;
   assign grant_rd_o  = busy_o && !own_wr_q;
   assign cmd_we_o    = grant_wr_o;
   assign cmd_addr_o  = in_idle ? '0 : (own_wr_q ? wr_base + wr_off_q : rd_base + rd_off_q);
   assign dbg_state_o = state_q;
endmodule
